fetch_unit: RTL



---
 rtl/fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential-PC instruction fetch with a credit-limited fetch queue,
// in-order imem requests and redirect flush that drops stale in-flight responses.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d
);
  localparam int             CW    = $clog2(DEPTH + 1);
  localparam int             PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LASTP = PW'(DEPTH - 1);
  localparam logic [31:0]    NOP   = 32'h0000_0013;

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [31:0]     qi_q [DEPTH];
  logic [XLEN-1:0] qp_q [DEPTH];
  logic [XLEN-1:0] sp_q [DEPTH];
  logic [PW-1:0]   hd_q, hd_d, tl_q, tl_d, sh_q, sh_d, st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d, os_q, os_d, dis_q, dis_d;
  logic [31:0]     li_q;
  logic [XLEN-1:0] lp_q;
  logic            acc, enq, deq, drop;
  logic            unused_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LASTP) ? '0 : p + 1'b1;
  endfunction

  assign unused_ok      = ^redirect_pc_e[1:0];
  assign imem_req_valid = !redirect_e && (({1'b0, cnt_q} + {1'b0, os_q}) < (CW+1)'(DEPTH));
  assign imem_addr      = pc_f_q;
  assign acc            = imem_req_valid && imem_req_ready;
  assign drop           = imem_resp_valid && os_q != '0;
  assign enq            = imem_resp_valid && !redirect_e && dis_q == '0;
  assign valid_d        = cnt_q != '0;
  assign deq            = valid_d && !stall_d;
  assign instr_d        = valid_d ? qi_q[hd_q] : li_q;
  assign pc_d           = valid_d ? qp_q[hd_q] : lp_q;
  assign pc_plus4_d     = pc_d + XLEN'(4);

  // After a redirect every in-flight request is stale, so discard tracks outstanding.
  always_comb begin
    pc_f_d = redirect_e ? {redirect_pc_e[XLEN-1:2], 2'b00} : acc ? pc_f_q + XLEN'(4) : pc_f_q;
    os_d   = os_q + CW'(acc) - CW'(drop);
    dis_d  = redirect_e ? os_q - CW'(drop) : dis_q - CW'(imem_resp_valid && dis_q != '0);
    hd_d   = redirect_e ? tl_q : deq ? inc(hd_q) : hd_q;
    tl_d   = enq ? inc(tl_q) : tl_q;
    cnt_d  = redirect_e ? '0 : cnt_q + CW'(enq) - CW'(deq);
    st_d   = acc ? inc(st_q) : st_q;
    sh_d   = imem_resp_valid ? inc(sh_q) : sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q <= RESET_PC;
      hd_q   <= '0;
      tl_q   <= '0;
      sh_q   <= '0;
      st_q   <= '0;
      cnt_q  <= '0;
      os_q   <= '0;
      dis_q  <= '0;
      li_q   <= NOP;
      lp_q   <= '0;
    end else begin
      pc_f_q <= pc_f_d;
      hd_q   <= hd_d;
      tl_q   <= tl_d;
      sh_q   <= sh_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      os_q   <= os_d;
      dis_q  <= dis_d;
      if (deq) begin
        li_q <= qi_q[hd_q];
        lp_q <= qp_q[hd_q];
      end
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      qi_q[tl_q] <= imem_resp_data;
      qp_q[tl_q] <= sp_q[sh_q];
    end
    if (acc) sp_q[st_q] <= pc_f_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(enq && !deq && cnt_q == CW'(DEPTH)));
      assert (!(imem_resp_valid && os_q == '0));
    end
  end
endmodule
